mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 27 ++
 rtl/mdu_div_core.sv | 73 +++++++
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ITERS  = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Magnitude of a two's-complement operand; unsigned operands pass through.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                input logic is_signed);
    return (is_signed && x[DATA_W-1]) ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider: one quotient bit per step on operand magnitudes, sign fix-up on the way out.
module mdu_div_core
  import mul_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quo_c_o,
  output logic [DATA_W-1:0] rem_c_o
);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dvs_zero_q, dvs_zero_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  always_comb begin
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    dvs_zero_d = dvs_zero_q;
    shifted    = {rem_q, quo_q[DATA_W-1]};
    diff       = shifted - {1'b0, dvs_q};
    if (load_i) begin
      rem_d      = '0;
      quo_d      = abs_val(dividend_i, signed_i);
      dvs_d      = abs_val(divisor_i, signed_i);
      quo_neg_d  = signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
      rem_neg_d  = signed_i && dividend_i[DATA_W-1];
      dvs_zero_d = (divisor_i == '0);
    end else if (step_i) begin
      if (!diff[DATA_W]) begin
        rem_d = diff[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end
    // Divide-by-zero keeps the all-ones quotient; the remainder fix-up restores the dividend.
    quo_c_o = (quo_neg_q && !dvs_zero_q) ? DATA_W'(-quo_d) : quo_d;
    rem_c_o = rem_neg_q ? DATA_W'(-rem_d) : rem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      dvs_zero_q <= dvs_zero_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32-iteration controller, shift-add multiplier, HI/LO registers.
// Define MDU_FAST_MUL_EN for single-cycle MULT/MULTU.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              cancel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                is_div_q, is_div_d;
  logic [2*DATA_W-1:0] prod_q, prod_d, prod_step, mul_res;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic                mneg_q, mneg_d;
  logic [DATA_W:0]     psum;
  logic                mul_signed, div_load, div_step;
  logic [DATA_W-1:0]   div_quo, div_rem;
`ifdef MDU_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_a, fast_b, fast_prod;
`endif

  mdu_div_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (div_load),
    .step_i    (div_step),
    .signed_i  (op == OP_DIV),
    .dividend_i(data_a),
    .divisor_i (data_b),
    .quo_c_o   (div_quo),
    .rem_c_o   (div_rem)
  );

  // Shift-add step: conditionally add the multiplicand into the top half, shift right.
  always_comb begin
    mul_signed = (op == OP_MULT);
    psum       = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step  = {psum, prod_q[DATA_W-1:1]};
    mul_res    = mneg_q ? (2*DATA_W)'(-prod_step) : prod_step;
`ifdef MDU_FAST_MUL_EN
    fast_a     = {{DATA_W{mul_signed & data_a[DATA_W-1]}}, data_a};
    fast_b     = {{DATA_W{mul_signed & data_b[DATA_W-1]}}, data_b};
    fast_prod  = fast_a * fast_b;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mneg_d   = mneg_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              mcand_d  = abs_val(data_a, mul_signed);
              prod_d   = {{DATA_W{1'b0}}, abs_val(data_b, mul_signed)};
              mneg_d   = mul_signed && (data_a[DATA_W-1] ^ data_b[DATA_W-1]);
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              is_div_d = 1'b1;
              cnt_d    = '0;
              state_d  = ST_RUN;
            end
            OP_MTHI: hi_d = data_a;
            OP_MTLO: lo_d = data_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          div_step = is_div_q;
          prod_d   = prod_step;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            {hi_d, lo_d} = is_div_q ? {div_rem, div_quo} : mul_res;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mneg_q   <= mneg_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
